// File: rtl/light_dance_pkg.sv
// Shared definitions for the light dance sequencer.
// Holds the datapath widths, the feedback-source encodings and the FSM state type.
package light_dance_pkg;

  localparam int unsigned LD_W  = 8;
  localparam int unsigned DIV_W = 4;
  localparam int unsigned CNT_W = 8;

  // din_sel encodings
  localparam logic [1:0] FbZero = 2'd0;
  localparam logic [1:0] FbOne  = 2'd1;
  localparam logic [1:0] FbDin  = 2'd2;
  localparam logic [1:0] FbMsb  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StHold,
    StDone
  } state_e;

endpackage

// File: rtl/light_dance_next.sv
// Next-pattern function of the light sequencer (purely combinational).
// Ports:
//   q  - current light pattern
//   fb - feedback bit shifted into bit 7
//   n  - next light pattern
module light_dance_next
  import light_dance_pkg::*;
(
  input  logic [LD_W-1:0] q,
  input  logic            fb,
  output logic [LD_W-1:0] n
);

  always_comb begin
    n[7] = q[0] ^ fb;
    n[6] = q[7];
    n[5] = q[0] ^ q[6];
    n[4] = q[0] ^ q[5];
    n[3] = q[4];
    n[2] = q[3];
    n[1] = q[0] ^ q[2];
    n[0] = q[0] ^ q[1];
  end

endmodule

// File: rtl/light_dance_ctrl.sv
// Light dance controller: loads a seed pattern, then steps it through
// light_dance_next once every div+1 cycles, for a frame of `steps` steps
// (0 = free-run until stop). pause freezes sequencing, stop aborts.
// Ports:
//   clk, arst           - clock, synchronous active-high reset
//   start, stop, pause  - sequence control
//   seed, div, steps    - initial pattern, prescale, steps per frame
//   din_sel, din        - feedback source select, external feedback bit
//   lights              - current pattern (registered)
//   busy                - high in LOAD, RUN and HOLD
//   step_pulse          - high the cycle a new stepped pattern first appears
//   done                - one-cycle pulse when a frame completes
module light_dance_ctrl
  import light_dance_pkg::*;
(
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [LD_W-1:0]  seed,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] steps,
  input  logic [1:0]       din_sel,
  input  logic             din,
  output logic [LD_W-1:0]  lights,
  output logic             busy,
  output logic             step_pulse,
  output logic             done
);

  state_e           state_q;
  logic [LD_W-1:0]  lights_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] psc_q;
  logic [CNT_W-1:0] steps_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       din_sel_q;
  logic             busy_q;
  logic             step_pulse_q;
  logic             done_q;

  logic             fb;
  logic [LD_W-1:0]  lights_next;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    fb = 1'b0;
    unique case (din_sel_q)
      FbZero:  fb = 1'b0;
      FbOne:   fb = 1'b1;
      FbDin:   fb = din;
      FbMsb:   fb = lights_q[LD_W-1];
      default: fb = 1'b0;
    endcase
  end

  assign cnt_inc = cnt_q + 1'b1;

  light_dance_next u_next (
    .q  (lights_q),
    .fb (fb),
    .n  (lights_next)
  );

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q      <= StIdle;
      lights_q     <= '0;
      div_q        <= '0;
      psc_q        <= '0;
      steps_q      <= '0;
      cnt_q        <= '0;
      din_sel_q    <= FbZero;
      busy_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !stop) begin
            div_q     <= div;
            steps_q   <= steps;
            din_sel_q <= din_sel;
            busy_q    <= 1'b1;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            // An all-zero pattern would never leave zero with fb = 0.
            lights_q <= (seed == '0) ? LD_W'(1) : seed;
            psc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= pause ? StHold : StRun;
          end
        end
        // HOLD with pause low resumes in the same cycle, so sequencing is
        // delayed by exactly the number of cycles pause was high.
        StRun, StHold: begin
          if (stop) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (pause) begin
            state_q <= StHold;
          end else if (psc_q == div_q) begin
            lights_q     <= lights_next;
            psc_q        <= '0;
            cnt_q        <= cnt_inc;
            step_pulse_q <= 1'b1;
            if ((steps_q != '0) && (cnt_inc == steps_q)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StRun;
            end
          end else begin
            psc_q   <= psc_q + 1'b1;
            state_q <= StRun;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign lights     = lights_q;
  assign busy       = busy_q;
  assign step_pulse = step_pulse_q;
  assign done       = done_q;

endmodule

// File: tb/tb_light_dance_ctrl.sv
// Bench for light_dance_ctrl: directed scenarios followed by random stimulus,
// every cycle checked against a behavioural model of the sequencer.
module tb_light_dance_ctrl;

  logic       clk = 1'b0;
  logic       arst, start, stop, pause, din;
  logic [7:0] seed, steps;
  logic [3:0] div;
  logic [1:0] din_sel;
  logic [7:0] lights;
  logic       busy, step_pulse, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  light_dance_ctrl dut (
    .clk        (clk),
    .arst       (arst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .seed       (seed),
    .div        (div),
    .steps      (steps),
    .din_sel    (din_sel),
    .din        (din),
    .lights     (lights),
    .busy       (busy),
    .step_pulse (step_pulse),
    .done       (done)
  );

  // Behavioural model: sequence-active flag, pending-load flag, cycles left
  // until the next step and steps taken so far in the frame.
  bit         m_seq, m_loading, m_done, m_pulse;
  logic [7:0] m_lights;
  int         m_left, m_taken;
  int         l_div, l_steps, l_sel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Shift right with fb entering the top, then xor the tap mask when q0 is set.
  function automatic logic [7:0] ref_next(input logic [7:0] q, input logic fb);
    logic [7:0] sh;
    sh = {fb, q[7:1]};
    return q[0] ? (sh ^ 8'hB3) : sh;
  endfunction

  task automatic model_edge();
    logic fbv;
    m_pulse = 1'b0;
    if (arst) begin
      m_seq = 0; m_loading = 0; m_done = 0; m_lights = 8'h00;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_seq) begin
      if (start && !stop) begin
        l_div = int'(div); l_steps = int'(steps); l_sel = int'(din_sel);
        m_seq = 1; m_loading = 1;
      end
    end else if (stop) begin
      m_seq = 0; m_loading = 0;
    end else if (m_loading) begin
      m_lights  = (seed == 8'h00) ? 8'h01 : seed;
      m_left    = l_div + 1;
      m_taken   = 0;
      m_loading = 0;
    end else if (!pause) begin
      if (m_left == 1) begin
        case (l_sel)
          0:       fbv = 1'b0;
          1:       fbv = 1'b1;
          2:       fbv = din;
          default: fbv = m_lights[7];
        endcase
        m_lights = ref_next(m_lights, fbv);
        m_pulse  = 1'b1;
        m_taken++;
        m_left   = l_div + 1;
        if (l_steps != 0 && m_taken == l_steps) begin
          m_seq = 0; m_done = 1;
        end
      end else begin
        m_left--;
      end
    end
  endtask

  // One clock: model advances on the edge, outputs checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("lights", {24'd0, lights}, {24'd0, m_lights});
    check_eq("busy", {31'd0, busy}, {31'd0, m_seq});
    check_eq("step_pulse", {31'd0, step_pulse}, {31'd0, m_pulse});
    check_eq("done", {31'd0, done}, {31'd0, m_done});
  endtask

  task automatic quiet();
    arst = 0; start = 0; stop = 0; pause = 0; din = 0;
  endtask

  initial begin
    int pulses;
    arst = 1; start = 0; stop = 0; pause = 0; din = 0;
    seed = 8'h00; div = 4'd0; steps = 8'd0; din_sel = 2'd0;
    m_seq = 0; m_loading = 0; m_done = 0; m_pulse = 0; m_lights = 8'h00;
    m_left = 1; m_taken = 0; l_div = 0; l_steps = 0; l_sel = 0;
    tick();
    tick();
    quiet();
    tick();

    // seed 01, div 0, two steps: 01 -> B3 -> EA, done, IDLE holding EA
    seed = 8'h01; div = 4'd0; steps = 8'd2; din_sel = 2'd0; start = 1;
    tick();
    start = 0;
    tick();
    check_eq("sc1_load", {24'd0, lights}, 32'h01);
    tick();
    check_eq("sc1_step1", {24'd0, lights}, 32'hB3);
    tick();
    check_eq("sc1_step2", {24'd0, lights}, 32'hEA);
    check_eq("sc1_done", {31'd0, done}, 32'd1);
    tick();
    check_eq("sc1_idle", {24'd0, lights}, 32'hEA);
    tick();

    // zero seed is replaced by 01
    seed = 8'h00; steps = 8'd1; start = 1;
    tick();
    start = 0;
    tick();
    check_eq("sc2_load", {24'd0, lights}, 32'h01);
    tick();
    check_eq("sc2_step", {24'd0, lights}, 32'hB3);
    tick();

    // free-run with div 3: one step every 4 cycles; then stop
    seed = 8'h5A; div = 4'd3; steps = 8'd0; din_sel = 2'd3; start = 1;
    tick();
    start = 0;
    tick();
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (step_pulse) pulses++;
      if (i == 40) begin div = 4'd0; steps = 8'd1; end  // must not take effect
    end
    check_eq("sc3_pulses", pulses, 32'd20);
    pause = 1;
    for (int i = 0; i < 5; i++) tick();
    pause = 0;
    for (int i = 0; i < 6; i++) tick();
    stop = 1; pause = 1;
    tick();
    quiet();
    tick();

    // reset mid-run, then a normal start
    seed = 8'hC3; div = 4'd1; steps = 8'd9; din_sel = 2'd1; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 7; i++) tick();
    arst = 1;
    tick();
    arst = 0;
    tick();
    check_eq("sc4_busy", {31'd0, busy}, 32'd0);
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 25; i++) tick();

    // external feedback with din toggling, start during run ignored
    seed = 8'h81; div = 4'd0; steps = 8'd12; din_sel = 2'd2; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 16; i++) begin
      din = $urandom_range(0, 1);
      start = (i == 5);
      tick();
    end
    quiet();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      arst    = ($urandom_range(0, 249) == 0);
      start   = ($urandom_range(0, 5) == 0);
      stop    = ($urandom_range(0, 39) == 0);
      pause   = ($urandom_range(0, 4) == 0);
      din     = $urandom_range(0, 1);
      seed    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      div     = 4'($urandom_range(0, 3));
      steps   = 8'($urandom_range(0, 7));
      din_sel = 2'($urandom_range(0, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
